fir_seq_ctrl: RTL and testbench

Frame sequencer for the 16-bit FIR datapath. It accepts a framed sample stream over a valid/ready handshake and drives the FIR input register every cycle. It holds the datapath cleared between frames and flushes the delay line with zeros after the last sample. A latency-matched tag pipeline marks which FIR output words are valid and which one ends the frame.

---
 rtl/fir_seq_ctrl_if.sv | 28 ++
 rtl/fir_seq_ctrl.sv | 140 ++++++++++++++
 tb/tb_fir_seq_ctrl.sv | 196 +++++++++++++++++++
 3 files changed

// File: rtl/fir_seq_ctrl_if.sv
// Handshake and FIR-control bundle around the frame sequencer.
// The slave modport is the sequencer; the master modport is its environment.
interface fir_seq_ctrl_if #(
    parameter int unsigned DW = 16
);
    logic          s_valid;
    logic [DW-1:0] s_data;
    logic          s_last;
    logic          s_ready;
    logic          fir_clr;
    logic [DW-1:0] fir_din;
    logic [DW-1:0] fir_dout;
    logic          m_valid;
    logic [DW-1:0] m_data;
    logic          m_last;
    logic          busy;
    logic          underrun;

    modport slave (
        input  s_valid, s_data, s_last, fir_dout,
        output s_ready, fir_clr, fir_din, m_valid, m_data, m_last, busy, underrun
    );

    modport master (
        output s_valid, s_data, s_last, fir_dout,
        input  s_ready, fir_clr, fir_din, m_valid, m_data, m_last, busy, underrun
    );
endinterface

// File: rtl/fir_seq_ctrl.sv
// Frame sequencer for the FIR datapath: feeds samples, flushes the delay line and tags valid results.
// Define FIR_SEQ_FLUSH_EN to append FLUSH_LEN zero samples after each frame's last sample.
module fir_seq_ctrl #(
    parameter int unsigned DW        = 16,
    parameter int unsigned LATENCY   = 20,
    parameter int unsigned FLUSH_LEN = 32
) (
    input  logic           clk,
    input  logic           rst,
    fir_seq_ctrl_if.slave  bus
);
    // One counter serves both the flush and the drain phase.
    localparam int unsigned CNT_MAX = (LATENCY > FLUSH_LEN) ? LATENCY : FLUSH_LEN;
    localparam int unsigned CNT_W   = (CNT_MAX > 1) ? $clog2(CNT_MAX) : 1;

    localparam logic [1:0] S_IDLE  = 2'd0;
    localparam logic [1:0] S_RUN   = 2'd1;
    localparam logic [1:0] S_DRAIN = 2'd2;
`ifdef FIR_SEQ_FLUSH_EN
    localparam logic [1:0] S_FLUSH = 2'd3;
`endif

    logic [1:0]       state_q, state_d;
    logic [CNT_W-1:0] cnt_q, cnt_d;
    logic             s_ready_q, s_ready_d;
    logic             fir_clr_q, fir_clr_d;
    logic [DW-1:0]    fir_din_q, fir_din_d;
    logic             busy_q, busy_d;
    logic             underrun_q, underrun_d;
    logic [1:0]       tag_in_q, tag_in_d;
    logic [1:0]       tag_pipe_q [LATENCY];
    logic [1:0]       tag_pipe_d [LATENCY];
    logic             accept_c;

    assign accept_c = bus.s_valid & s_ready_q;

    // Next state, FIR input word and the {valid, last} tag that travels with it.
    always_comb begin
        state_d    = state_q;
        cnt_d      = cnt_q;
        fir_din_d  = '0;
        tag_in_d   = 2'b00;
        underrun_d = underrun_q;
        case (state_q)
            S_IDLE: begin
                if (bus.s_valid) begin
                    state_d    = S_RUN;
                    underrun_d = 1'b0;
                end
            end
            S_RUN: begin
                if (accept_c) begin
                    fir_din_d = bus.s_data;
`ifdef FIR_SEQ_FLUSH_EN
                    tag_in_d = 2'b10;
                    if (bus.s_last) begin
                        state_d = S_FLUSH;
                        cnt_d   = CNT_W'(FLUSH_LEN - 1);
                    end
`else
                    tag_in_d = {1'b1, bus.s_last};
                    if (bus.s_last) begin
                        state_d = S_DRAIN;
                        cnt_d   = CNT_W'(LATENCY - 1);
                    end
`endif
                end else begin
                    underrun_d = 1'b1;
                end
            end
`ifdef FIR_SEQ_FLUSH_EN
            S_FLUSH: begin
                tag_in_d = {1'b1, cnt_q == '0};
                cnt_d    = cnt_q - CNT_W'(1);
                if (cnt_q == '0) begin
                    state_d = S_DRAIN;
                    cnt_d   = CNT_W'(LATENCY - 1);
                end
            end
`endif
            S_DRAIN: begin
                cnt_d = cnt_q - CNT_W'(1);
                if (cnt_q == '0) begin
                    state_d = S_IDLE;
                end
            end
            default: begin
                state_d = S_IDLE;
            end
        endcase
        s_ready_d = (state_d == S_RUN);
        busy_d    = (state_d != S_IDLE);
        // Clear follows the state one edge late so it drops together with the first accepted sample.
        fir_clr_d = (state_q == S_IDLE);
    end

    always_comb begin
        tag_pipe_d[0] = tag_in_q;
        for (int i = 1; i < int'(LATENCY); i++) begin
            tag_pipe_d[i] = tag_pipe_q[i-1];
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q    <= S_IDLE;
            cnt_q      <= '0;
            s_ready_q  <= 1'b0;
            fir_clr_q  <= 1'b1;
            fir_din_q  <= '0;
            busy_q     <= 1'b0;
            underrun_q <= 1'b0;
            tag_in_q   <= 2'b00;
            for (int i = 0; i < int'(LATENCY); i++) begin
                tag_pipe_q[i] <= 2'b00;
            end
        end else begin
            state_q    <= state_d;
            cnt_q      <= cnt_d;
            s_ready_q  <= s_ready_d;
            fir_clr_q  <= fir_clr_d;
            fir_din_q  <= fir_din_d;
            busy_q     <= busy_d;
            underrun_q <= underrun_d;
            tag_in_q   <= tag_in_d;
            for (int i = 0; i < int'(LATENCY); i++) begin
                tag_pipe_q[i] <= tag_pipe_d[i];
            end
        end
    end

    assign bus.s_ready  = s_ready_q;
    assign bus.fir_clr  = fir_clr_q;
    assign bus.fir_din  = fir_din_q;
    assign bus.busy     = busy_q;
    assign bus.underrun = underrun_q;
    assign bus.m_valid  = tag_pipe_q[LATENCY-1][1];
    assign bus.m_last   = tag_pipe_q[LATENCY-1][0];
    assign bus.m_data   = bus.fir_dout;
endmodule

// File: tb/tb_fir_seq_ctrl.sv
// Scoreboard bench for fir_seq_ctrl: frames are expanded into expected result words,
// and a monitor pops and compares them whenever m_valid is presented.
module tb_fir_seq_ctrl;
    localparam int unsigned DW        = 16;
    localparam int unsigned LATENCY   = 20;
    localparam int unsigned FLUSH_LEN = 32;
`ifdef FIR_SEQ_FLUSH_EN
    localparam bit FLUSH_EN = 1'b1;
`else
    localparam bit FLUSH_EN = 1'b0;
`endif
    localparam int TAIL = FLUSH_EN ? int'(FLUSH_LEN) : 0;

    logic clk = 1'b0;
    logic rst = 1'b1;
    always #5 clk = ~clk;

    fir_seq_ctrl_if #(.DW(DW)) bus ();

    fir_seq_ctrl #(.DW(DW), .LATENCY(LATENCY), .FLUSH_LEN(FLUSH_LEN)) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    // Stand-in FIR: a pure LATENCY-cycle delay of fir_din, so each result word equals its input sample.
    logic [DW-1:0] dl [LATENCY];
    always @(posedge clk) begin
        for (int i = int'(LATENCY) - 1; i > 0; i--) dl[i] <= dl[i-1];
        dl[0] <= bus.fir_din;
    end
    assign bus.fir_dout = dl[LATENCY-1];

    int cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    int n_cmp  = 0;
    int n_fail = 0;
    logic [DW:0] exp_q [$];
    int mv_cnt, ml_cnt, first_mv, last_acc;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0d (0x%0h), expected %0d (0x%0h) at cycle %0d", name, act, act, exp, exp, cyc);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // Monitor: every presented result word must match the head of the expected queue.
    always @(negedge clk) begin
        logic [DW:0] e;
        if (!rst && bus.m_valid === 1'b1) begin
            mv_cnt++;
            if (bus.m_last === 1'b1) ml_cnt++;
            if (first_mv < 0) first_mv = cyc;
            if (exp_q.size() == 0) begin
                n_cmp++;
                n_fail++;
                $display("FAIL unexpected_m_valid: m_valid=1 at cycle %0d, no result expected", cyc);
            end else begin
                e = exp_q.pop_front();
                chk("m_data", 32'(bus.m_data), 32'(e[DW-1:0]));
                chk("m_last", 32'(bus.m_last), 32'(e[DW]));
            end
        end
    end

    // Drive one frame of n samples; gap_at forces one empty RUN cycle before sample gap_at,
    // gap_pct adds random empty cycles, abort_at pulses rst instead of sending that sample.
    task automatic send_frame(input int n, input int gap_at, input int abort_at, input int gap_pct);
        int i, budget, first_acc, wait_cyc, k;
        bit gap_done, v, acc, gapped;
        logic [DW-1:0] d;
        logic [DW:0] w;
        i = 0; budget = 0; first_acc = -1; wait_cyc = 0; gap_done = 1'b0;
        mv_cnt = 0; ml_cnt = 0; first_mv = -1;
        while (i < n && budget < 2000) begin
            if (i == abort_at) begin
                bus.s_valid = 1'b0;
                bus.s_last  = 1'b0;
                rst = 1'b1;
                exp_q.delete();
                tick();
                chk("abort_s_ready", 32'(bus.s_ready), 32'(0));
                chk("abort_fir_clr", 32'(bus.fir_clr), 32'(1));
                chk("abort_m_valid", 32'(bus.m_valid), 32'(0));
                chk("abort_busy", 32'(bus.busy), 32'(0));
                rst = 1'b0;
                return;
            end
            v = 1'b1;
            if (bus.s_ready && i == gap_at && !gap_done) begin
                v = 1'b0;
                gap_done = 1'b1;
            end else if (bus.s_ready && i > 0 && int'($urandom_range(0, 99)) < gap_pct) begin
                v = 1'b0;
            end
            d = DW'($urandom);
            bus.s_valid = v;
            bus.s_data  = d;
            bus.s_last  = (i == n - 1);
            acc    = v && bus.s_ready;
            gapped = !v;
            if (acc) begin
                if (i == 0) chk("pre_start_fir_clr", 32'(bus.fir_clr), 32'(1));
                w = {((i == n - 1) && !FLUSH_EN), d};
                exp_q.push_back(w);
                if (first_acc < 0) first_acc = cyc + 1;
                last_acc = cyc + 1;
                i++;
            end else if (v) begin
                wait_cyc++;
            end
            tick();
            budget++;
            if (gapped) begin
                chk("gap_underrun", 32'(bus.underrun), 32'(1));
                chk("gap_fir_din", 32'(bus.fir_din), 32'(0));
            end
            if (acc && i == 1) begin
                chk("start_fir_clr", 32'(bus.fir_clr), 32'(0));
                chk("start_underrun", 32'(bus.underrun), 32'(0));
            end
            if (acc && i == n) begin
                chk("post_last_s_ready", 32'(bus.s_ready), 32'(0));
                chk("post_last_busy", 32'(bus.busy), 32'(1));
            end
        end
        bus.s_valid = 1'b0;
        bus.s_last  = 1'b0;
        chk("frame_accepted", 32'(i), 32'(n));
        chk("start_wait_cycles", 32'(wait_cyc), 32'(1));
        for (int j = 0; j < TAIL; j++) begin
            w = '0;
            w[DW] = (j == TAIL - 1);
            exp_q.push_back(w);
        end
        k = 0;
        while (bus.busy && k < 500) begin
            tick();
            k++;
        end
        chk("busy_fall_cycle", 32'(cyc), 32'(last_acc + TAIL + int'(LATENCY)));
        k = 0;
        while (exp_q.size() != 0 && k < 50) begin
            tick();
            k++;
        end
        chk("queue_drained", 32'(exp_q.size()), 32'(0));
        chk("m_valid_count", 32'(mv_cnt), 32'(n + TAIL));
        chk("m_last_count", 32'(ml_cnt), 32'(1));
        chk("first_result_delay", 32'(first_mv - first_acc), 32'(LATENCY));
    endtask

    initial begin
        bus.s_valid = 1'b0;
        bus.s_data  = '0;
        bus.s_last  = 1'b0;
        first_mv = -1; mv_cnt = 0; ml_cnt = 0; last_acc = 0;
        rst = 1'b1;
        tick();
        chk("reset_outputs", 32'({bus.s_ready, bus.fir_clr, bus.m_valid, bus.m_last, bus.busy, bus.underrun}), 32'(6'b010000));
        chk("reset_fir_din", 32'(bus.fir_din), 32'(0));
        tick();
        rst = 1'b0;
        for (int c = 0; c < 50; c++) begin
            tick();
            chk("idle_outputs", 32'({bus.s_ready, bus.fir_clr, bus.m_valid, bus.busy}), 32'(4'b0100));
        end

        send_frame(8, -1, -1, 0);
        send_frame(8, 3, -1, 0);
        send_frame(5, -1, -1, 0);
        send_frame(1, -1, -1, 0);

        send_frame(16, -1, 5, 0);
        for (int c = 0; c < int'(LATENCY) + 5; c++) begin
            tick();
            chk("abort_quiet_m_valid", 32'(bus.m_valid), 32'(0));
        end
        send_frame(8, -1, -1, 0);

        for (int f = 0; f < 6; f++) begin
            send_frame(int'($urandom_range(1, 12)), -1, -1, 25);
        end

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
        $finish;
    end
endmodule
